mem_stage: RTL and testbench

- MEM pipeline stage of the RV32IC core. Sits directly downstream of the EX-stage ALU and consumes its MEM_STATE outputs (ALU result, store data, mem_type, control bits, rd, pc).
- Performs data-memory loads and stores over a req/ack bus with wait states, including byte-lane alignment and load sign/zero extension.
- Drives the WB-stage registers and a pipeline stall back to IF/ID/EX.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : RV32IC MEM pipeline stage. Issues data-memory loads/stores over
//             a req/ack bus with wait states, aligns store lanes, extends load
//             data, and drives the WB-stage registers plus an upstream stall.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_mem_type,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  input  logic [4:0]  i_rd,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic [31:0] o_wb_pc,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_misaligned,
  output logic        o_timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] c_MT_B  = 4'b0001;
  localparam logic [3:0] c_MT_H  = 4'b0011;
  localparam logic [3:0] c_MT_W  = 4'b1111;
  localparam logic [3:0] c_MT_BU = 4'b1000;
  localparam logic [3:0] c_MT_HU = 4'b1100;
  // Last counter value of a WAIT before the access is abandoned.
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_mem_type;
  logic [1:0]  r_off;
  logic [31:0] r_pc;
  logic [31:0] r_alu_out;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_wb_valid;
  logic        r_wb_reg_write;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_misaligned;
  logic        r_timeout;

  logic        w_access;
  logic [1:0]  w_off;
  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;
  logic        w_timeout_hit;

  // Decode the incoming access: size class, alignment, byte lanes, store data.
  // Encodings outside the five legal ones are rejected like 0000.
  always_comb begin
    w_access     = i_valid & (i_mem_read | i_mem_write);
    w_off        = i_alu_out[1:0];
    w_is_b       = (i_mem_type == c_MT_B) | (i_mem_type == c_MT_BU);
    w_is_h       = (i_mem_type == c_MT_H) | (i_mem_type == c_MT_HU);
    w_is_w       = (i_mem_type == c_MT_W);
    w_misaligned = ~(w_is_b | w_is_h | w_is_w)
                 | (w_is_h & w_off[0])
                 | (w_is_w & (w_off != 2'b00));
    w_be         = 4'b0000;
    w_wdata      = i_store_data;
    if (w_is_b) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{i_store_data[7:0]}};
    end else if (w_is_h) begin
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{i_store_data[15:0]}};
    end else if (w_is_w) begin
      w_be    = 4'b1111;
      w_wdata = i_store_data;
    end
  end

  // Pick the addressed byte/half of the returned word and extend it.
  always_comb begin
    case (r_off)
      2'd0:    w_ld_byte = i_dmem_rdata[7:0];
      2'd1:    w_ld_byte = i_dmem_rdata[15:8];
      2'd2:    w_ld_byte = i_dmem_rdata[23:16];
      default: w_ld_byte = i_dmem_rdata[31:24];
    endcase
    w_ld_half = r_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_mem_type)
      c_MT_B:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      c_MT_BU: w_load_data = {24'h0, w_ld_byte};
      c_MT_H:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
      c_MT_HU: w_load_data = {16'h0, w_ld_half};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  // Timeout fires in the last allowed WAIT cycle when no ack arrives.
  always_comb begin
    w_timeout_hit = (r_state == S_WAIT) & ~i_dmem_ack & (r_cnt == c_TO_LAST);
    o_stall       = ((r_state == S_IDLE) & w_access & ~w_misaligned)
                  | ((r_state == S_WAIT) & ~i_dmem_ack & ~w_timeout_hit);
  end

  // Stage FSM: launch accesses, wait for ack/timeout, and load the WB registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= 32'd0;
      r_dmem_be      <= 4'd0;
      r_dmem_wdata   <= 32'd0;
      r_mem_type     <= 4'd0;
      r_off          <= 2'd0;
      r_pc           <= 32'd0;
      r_alu_out      <= 32'd0;
      r_rd           <= 5'd0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_pc        <= 32'd0;
      r_wb_data      <= 32'd0;
      r_wb_rd        <= 5'd0;
      r_misaligned   <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      // WB strobes and fault flags are single-cycle pulses.
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_misaligned   <= 1'b0;
      r_timeout      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access & ~w_misaligned) begin
            r_state      <= S_WAIT;
            r_cnt        <= 8'd0;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= i_mem_write;
            r_dmem_addr  <= {i_alu_out[31:2], 2'b00};
            r_dmem_be    <= w_be;
            r_dmem_wdata <= w_wdata;
            r_mem_type   <= i_mem_type;
            r_off        <= w_off;
            r_pc         <= i_pc;
            r_alu_out    <= i_alu_out;
            r_rd         <= i_rd;
            r_reg_write  <= i_reg_write;
            r_mem_to_reg <= i_mem_to_reg;
          end else if (w_access) begin
            r_wb_valid   <= 1'b1;
            r_misaligned <= 1'b1;
            r_wb_pc      <= i_pc;
            r_wb_data    <= i_alu_out;
            r_wb_rd      <= i_rd;
          end else begin
            r_wb_valid     <= i_valid;
            r_wb_reg_write <= i_reg_write & i_valid;
            r_wb_pc        <= i_pc;
            r_wb_data      <= i_alu_out;
            r_wb_rd        <= i_rd;
          end
        end
        S_WAIT: begin
          if (i_dmem_ack) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_dmem_req     <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_reg_write & ~r_dmem_we;
            r_wb_pc        <= r_pc;
            r_wb_data      <= (r_mem_to_reg & ~r_dmem_we) ? w_load_data : r_alu_out;
            r_wb_rd        <= r_rd;
          end else if (w_timeout_hit) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b1;
            r_timeout  <= 1'b1;
            r_wb_pc    <= r_pc;
            r_wb_data  <= r_alu_out;
            r_wb_rd    <= r_rd;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dmem_req     = r_dmem_req;
  assign o_dmem_we      = r_dmem_we;
  assign o_dmem_addr    = r_dmem_addr;
  assign o_dmem_be      = r_dmem_be;
  assign o_dmem_wdata   = r_dmem_wdata;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_reg_write = r_wb_reg_write;
  assign o_wb_pc        = r_wb_pc;
  assign o_wb_data      = r_wb_data;
  assign o_wb_rd        = r_wb_rd;
  assign o_misaligned   = r_misaligned;
  assign o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Directed scoreboard bench for mem_stage (TIMEOUT_CYCLES = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_alu_out;
  logic [31:0] i_store_data;
  logic [3:0]  i_mem_type;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_reg_write;
  logic        i_mem_to_reg;
  logic [4:0]  i_rd;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic        o_wb_valid;
  logic        o_wb_reg_write;
  logic [31:0] o_wb_pc;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_misaligned;
  logic        o_timeout;

  localparam logic [3:0] MT_B = 4'b0001, MT_H = 4'b0011, MT_W = 4'b1111;
  localparam logic [3:0] MT_BU = 4'b1000, MT_HU = 4'b1100, MT_NONE = 4'b0000;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc(i_pc),
    .i_alu_out(i_alu_out), .i_store_data(i_store_data), .i_mem_type(i_mem_type),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_rd(i_rd), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_wb_valid(o_wb_valid), .o_wb_reg_write(o_wb_reg_write),
    .o_wb_pc(o_wb_pc), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        to;
    logic        chk_data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every WB strobe is matched against the oldest expected retirement.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_wb_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_wb: got wb_valid with pc 0x%08h expected none", o_wb_pc);
        end else begin
          mon_e = q.pop_front();
          chk("wb_pc", o_wb_pc, mon_e.pc);
          chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, mon_e.rd});
          chk("wb_reg_write", {31'd0, o_wb_reg_write}, {31'd0, mon_e.rw});
          chk("wb_misaligned", {31'd0, o_misaligned}, {31'd0, mon_e.mis});
          chk("wb_timeout", {31'd0, o_timeout}, {31'd0, mon_e.to});
          if (mon_e.chk_data) chk("wb_data", o_wb_data, mon_e.data);
        end
      end else if (o_misaligned || o_timeout) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_pulse: got mis=%0b to=%0b expected 0 without wb_valid",
                 o_misaligned, o_timeout);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [3:0] mt, input logic rd_en,
                       input logic wr_en, input logic rw, input logic m2r,
                       input logic [4:0] rd);
    i_valid = v; i_pc = pc; i_alu_out = addr; i_store_data = sd; i_mem_type = mt;
    i_mem_read = rd_en; i_mem_write = wr_en; i_reg_write = rw; i_mem_to_reg = m2r;
    i_rd = rd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'd0, 32'd0, 32'd0, MT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Aligned load (wr=0) or store (wr=1) with ack after ack_wait stalled WAIT cycles.
  task automatic mem_op(input string nm, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [3:0] mt, input logic wr,
                        input logic [4:0] rd, input int ack_wait, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    exp_t e;
    int   stall_n;
    int   req_n;
    @(negedge clk);
    drive(1'b1, pc, addr, sd, mt, ~wr, wr, ~wr, ~wr, rd);
    e = '{pc, exp_data, rd, ~wr, 1'b0, 1'b0, ~wr};
    q.push_back(e);
    stall_n = 0;
    req_n   = 0;
    #1;
    chk({nm, "_req_in_idle"}, {31'd0, o_dmem_req}, 32'd0);
    if (o_stall) stall_n++;
    @(negedge clk);
    chk({nm, "_addr"}, o_dmem_addr, {addr[31:2], 2'b00});
    chk({nm, "_be"}, {28'd0, o_dmem_be}, {28'd0, exp_be});
    chk({nm, "_we"}, {31'd0, o_dmem_we}, {31'd0, wr});
    if (wr) chk({nm, "_wdata"}, o_dmem_wdata, exp_wdata);
    for (int k = 0; k < ack_wait; k++) begin
      #1;
      if (o_stall) stall_n++;
      if (o_dmem_req) req_n++;
      @(negedge clk);
    end
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = rdata;
    #1;
    chk({nm, "_stall_on_ack"}, {31'd0, o_stall}, 32'd0);
    if (o_dmem_req) req_n++;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    idle_inputs();
    #1;
    chk({nm, "_req_after"}, {31'd0, o_dmem_req}, 32'd0);
    chk({nm, "_stall_cycles"}, stall_n, 1 + ack_wait);
    chk({nm, "_req_cycles"}, req_n, 1 + ack_wait);
  endtask

  task automatic mis_op(input string nm, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [3:0] mt, input logic wr, input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    drive(1'b1, pc, addr, 32'h1111_2222, mt, ~wr, wr, ~wr, ~wr, rd);
    e = '{pc, 32'd0, rd, 1'b0, 1'b1, 1'b0, 1'b0};
    q.push_back(e);
    #1;
    chk({nm, "_stall"}, {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    chk({nm, "_no_req"}, {31'd0, o_dmem_req}, 32'd0);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    int   s;
    i_reset = 1'b1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = 32'd0;
    idle_inputs();
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rst_we", {31'd0, o_dmem_we}, 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_be", {28'd0, o_dmem_be}, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rst_wb_pc", o_wb_pc, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("rst_flags", {30'd0, o_misaligned, o_timeout}, 32'd0);

    // Pass-through ADD result
    @(negedge clk);
    drive(1'b1, 32'h0000_0100, 32'h0000_0007, 32'd0, MT_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
    e = '{32'h0000_0100, 32'h0000_0007, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1};
    q.push_back(e);
    #1 chk("pass_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0104, 32'hDEAD_0001, 32'd0, MT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9);
    e = '{32'h0000_0104, 32'hDEAD_0001, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1};
    q.push_back(e);
    #1 chk("pass2_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    idle_inputs();

    // Stores
    mem_op("sb", 32'h200, 32'h0000_1003, 32'hAABB_CCDD, MT_B, 1'b1, 5'd1, 3, 32'd0,
           4'b1000, 32'hDDDD_DDDD, 32'd0);
    mem_op("sh", 32'h204, 32'h0000_1002, 32'h1234_ABCD, MT_H, 1'b1, 5'd2, 1, 32'd0,
           4'b1100, 32'hABCD_ABCD, 32'd0);
    mem_op("sw", 32'h208, 32'h0000_1004, 32'hCAFE_F00D, MT_W, 1'b1, 5'd3, 0, 32'd0,
           4'b1111, 32'hCAFE_F00D, 32'd0);

    // Loads
    mem_op("lb", 32'h300, 32'h0000_2001, 32'd0, MT_B, 1'b0, 5'd10, 0, 32'h0000_8000,
           4'b0010, 32'd0, 32'hFFFF_FF80);
    mem_op("lbu", 32'h304, 32'h0000_2001, 32'd0, MT_BU, 1'b0, 5'd11, 0, 32'h0000_8000,
           4'b0010, 32'd0, 32'h0000_0080);
    mem_op("lh", 32'h308, 32'h0000_2002, 32'd0, MT_H, 1'b0, 5'd12, 2, 32'h8001_0000,
           4'b1100, 32'd0, 32'hFFFF_8001);
    mem_op("lhu", 32'h30C, 32'h0000_2002, 32'd0, MT_HU, 1'b0, 5'd13, 0, 32'h8001_0000,
           4'b1100, 32'd0, 32'h0000_8001);
    mem_op("lb3", 32'h310, 32'h0000_2003, 32'd0, MT_B, 1'b0, 5'd14, 1, 32'h7F00_0000,
           4'b1000, 32'd0, 32'h0000_007F);
    mem_op("lw", 32'h314, 32'h0000_2004, 32'd0, MT_W, 1'b0, 5'd15, 1, 32'h1234_5678,
           4'b1111, 32'd0, 32'h1234_5678);

    // Misaligned / invalid
    mis_op("lw_mis", 32'h400, 32'h0000_2002, MT_W, 1'b0, 5'd20);
    mis_op("lh_mis", 32'h404, 32'h0000_2001, MT_H, 1'b0, 5'd21);
    mis_op("sw_mis", 32'h408, 32'h0000_1001, MT_W, 1'b1, 5'd22);
    mis_op("type0", 32'h40C, 32'h0000_2000, MT_NONE, 1'b0, 5'd23);

    // Timeout: no ack ever
    @(negedge clk);
    drive(1'b1, 32'h500, 32'h0000_1008, 32'h5555_AAAA, MT_W, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
    e = '{32'h500, 32'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    q.push_back(e);
    @(negedge clk);
    n = 0;
    s = 0;
    while (o_dmem_req && n < 20) begin
      #1;
      if (o_stall) s++;
      n++;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("to_req_cycles", n, 4);
    chk("to_stall_cycles", s, 3);
    chk("to_req_after", {31'd0, o_dmem_req}, 32'd0);
    chk("to_stall_after", {31'd0, o_stall}, 32'd0);

    // Reset during the 2nd WAIT cycle, late ack afterwards
    @(negedge clk);
    drive(1'b1, 32'h600, 32'h0000_3000, 32'd0, MT_W, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    idle_inputs();
    i_reset = 1'b0;
    #1;
    chk("rwait_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rwait_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rwait_addr", o_dmem_addr, 32'd0);
    chk("rwait_wb_pc", o_wb_pc, 32'd0);
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'd0, o_dmem_req}, 32'd0);
    chk("late_ack_wb_valid", {31'd0, o_wb_valid}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
